// File: rtl/iir_decim_fifo.sv
// Block-average decimator on the IIR output feeding a small first-word-fall-through FIFO.
// Define DECIM_ROUND_EN to round half up (with saturation) instead of truncating.
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | no partial block; next sample starts a block
// ST_ACC  | accumulating samples of the current block
module iir_decim_fifo #(
    parameter int DATA_W     = 8,
    parameter int MAX_LOG2   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               din,
    input  logic                            din_en,
    input  logic [2:0]                      dec_sel,
    output logic [DATA_W-1:0]               dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            ovf,
    input  logic                            clr_ovf
);

    localparam int ACC_W = DATA_W + MAX_LOG2;
    localparam int SUM_W = ACC_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [MAX_LOG2-1:0] cnt_q, cnt_d;
    logic [2:0]          k_q, k_d;
    logic [2:0]          k_eff;
    logic [MAX_LOG2-1:0] cnt_last;
    logic [SUM_W-1:0]    sum;
    logic [DATA_W-1:0]   result;
    logic                push;
    logic [DATA_W-1:0]   push_data;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    level_q;
    logic                ovf_q;
    logic                full, pop, wr_en, drop;

    assign k_eff    = (dec_sel > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : dec_sel;
    assign cnt_last = MAX_LOG2'((32'd1 << k_q) - 32'd1);
    assign sum      = SUM_W'(acc_q) + SUM_W'(din);

`ifdef DECIM_ROUND_EN
    logic [SUM_W-1:0] rounded;
    always_comb begin
        rounded = (sum + SUM_W'((32'd1 << k_q) >> 1)) >> k_q;
        // An all-ones block plus the rounding bias must not wrap to zero
        result  = (|rounded[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : rounded[DATA_W-1:0];
    end
`else
    assign result = DATA_W'(sum >> k_q);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (din_en) begin
                    k_d = k_eff;
                    if (k_eff == 3'd0) begin
                        push      = 1'b1;
                        push_data = din;
                    end else begin
                        acc_d   = ACC_W'(din);
                        cnt_d   = MAX_LOG2'(1);
                        state_d = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (din_en) begin
                    if (cnt_q == cnt_last) begin
                        push      = 1'b1;
                        push_data = result;
                        state_d   = ST_IDLE;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                        cnt_d = cnt_q + MAX_LOG2'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push at full still lands
    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop   = (level_q != '0) && dout_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            level_q <= level_q + LVL_W'(wr_en) - LVL_W'(pop);
            if (drop)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign dout_valid = (level_q != '0);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;
    assign level      = level_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_iir_decim_fifo.sv
// Self-checking bench for iir_decim_fifo: directed scenarios plus random traffic
// compared against a queue-based model of block averaging and FIFO behaviour.
module tb_iir_decim_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = '0;
    logic       din_en = 1'b0;
    logic [2:0] dec_sel = '0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic [2:0] level;
    logic       ovf;
    logic       clr_ovf = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int q[$];
    int blk[$];
    int m_k = 0;
    bit m_ovf = 0;

    iir_decim_fifo #(.DATA_W(8), .MAX_LOG2(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .dec_sel(dec_sel),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .level(level), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic int block_result(int k);
        int s = 0;
        int r;
        foreach (blk[i]) s += blk[i];
        if (k == 0) return s;
`ifdef DECIM_ROUND_EN
        r = (s + (1 << (k - 1))) / (1 << k);
        if (r > 255) r = 255;
`else
        r = s / (1 << k);
`endif
        return r;
    endfunction

    function automatic void model_edge();
        bit pop, full_before, have_res, drop;
        int res = 0;
        if (!rst) begin
            q.delete();
            blk.delete();
            m_ovf = 0;
            return;
        end
        pop = (q.size() > 0) && dout_ready;
        have_res = 0;
        drop = 0;
        if (din_en) begin
            if (blk.size() == 0) m_k = (int'(dec_sel) > 4) ? 4 : int'(dec_sel);
            blk.push_back(int'(din));
            if (blk.size() == (1 << m_k)) begin
                res = block_result(m_k);
                have_res = 1;
                blk.delete();
            end
        end
        full_before = (q.size() == DEPTH);
        if (pop) void'(q.pop_front());
        if (have_res) begin
            if (!full_before || pop) q.push_back(res);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        din_en = 0; din = '0; clr_ovf = 0;
    endtask

    task automatic test_reset();
        rst = 0; idle_inputs(); dout_ready = 1;
        step(); step();
        rst = 1;
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", dout_valid); end
        n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %0h expected 0", dout); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
    endtask

    task automatic test_passthrough();
        logic [7:0] vals [3] = '{8'h10, 8'h20, 8'h30};
        dec_sel = 0; dout_ready = 1;
        foreach (vals[i]) begin
            din_en = 1; din = vals[i];
            step();
            n_tests++; if (dout_valid !== 1'b1 || dout !== vals[i]) begin
                n_fail++; $display("FAIL pass_dout[%0d]: got %0b/%0h expected 1/%0h", i, dout_valid, dout, vals[i]);
            end
            n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL pass_level[%0d]: got %0d expected 1", i, level); end
        end
        idle_inputs(); step();
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL pass_drain: got %0d expected 0", level); end
    endtask

    task automatic test_avg4();
        logic [7:0] exp_v;
`ifdef DECIM_ROUND_EN
        exp_v = 8'h03;
`else
        exp_v = 8'h02;
`endif
        dec_sel = 2; dout_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            din_en = 1; din = 8'(i);
            step();
            if (i < 4) begin
                n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL avg4_early[%0d]: got valid %0b expected 0", i, dout_valid); end
            end
        end
        n_tests++; if (dout_valid !== 1'b1 || dout !== exp_v) begin
            n_fail++; $display("FAIL avg4_result: got %0b/%0h expected 1/%0h", dout_valid, dout, exp_v);
        end
        idle_inputs(); step();
    endtask

    task automatic test_max_block();
        dout_ready = 0; dec_sel = 4;
        for (int i = 0; i < 16; i++) begin
            din_en = 1; din = 8'hFF;
            step();
            if (i == 0) dec_sel = 0;
        end
        idle_inputs();
        n_tests++; if (dout_valid !== 1'b1 || dout !== 8'hFF || level !== 3'd1) begin
            n_fail++; $display("FAIL max_ff: got %0b/%0h lvl %0d expected 1/ff lvl 1", dout_valid, dout, level);
        end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL max_ovf: got %0b expected 0", ovf); end
        dout_ready = 1; step();
        dec_sel = 7;
        for (int i = 0; i < 16; i++) begin
            din_en = 1; din = 8'h01;
            step();
            if (i == 14) begin
                n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_early: got valid %0b expected 0", dout_valid); end
            end
        end
        idle_inputs();
        n_tests++; if (dout_valid !== 1'b1 || dout !== 8'h01) begin
            n_fail++; $display("FAIL clamp_result: got %0b/%0h expected 1/01", dout_valid, dout);
        end
        step();
    endtask

    task automatic test_full_fifo();
        dout_ready = 0; dec_sel = 0;
        for (int i = 0; i < 5; i++) begin
            din_en = 1; din = 8'hA1 + 8'(i);
            step();
            if (i == 3) begin
                n_tests++; if (ovf !== 1'b0 || level !== 3'd4) begin
                    n_fail++; $display("FAIL full_4th: got ovf %0b lvl %0d expected 0 lvl 4", ovf, level);
                end
            end
        end
        idle_inputs();
        n_tests++; if (ovf !== 1'b1 || level !== 3'd4) begin
            n_fail++; $display("FAIL full_5th: got ovf %0b lvl %0d expected 1 lvl 4", ovf, level);
        end
        dout_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (dout_valid !== 1'b1 || dout !== 8'hA1 + 8'(i)) begin
                n_fail++; $display("FAIL drain[%0d]: got %0b/%0h expected 1/%0h", i, dout_valid, dout, 8'hA1 + 8'(i));
            end
            step();
        end
        n_tests++; if (dout_valid !== 1'b0 || dout !== 8'h00) begin
            n_fail++; $display("FAIL drain_empty: got %0b/%0h expected 0/00", dout_valid, dout);
        end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", ovf); end
        clr_ovf = 1; step(); clr_ovf = 0;
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %0b expected 0", ovf); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_v [4] = '{8'h52, 8'h53, 8'h54, 8'h55};
        dout_ready = 0; dec_sel = 0;
        for (int i = 0; i < 4; i++) begin
            din_en = 1; din = 8'h51 + 8'(i);
            step();
        end
        dout_ready = 1; din_en = 1; din = 8'h55;
        step();
        idle_inputs();
        n_tests++; if (level !== 3'd4 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL pp_full: got lvl %0d ovf %0b expected lvl 4 ovf 0", level, ovf);
        end
        foreach (exp_v[i]) begin
            n_tests++; if (dout !== exp_v[i]) begin
                n_fail++; $display("FAIL pp_drain[%0d]: got %0h expected %0h", i, dout, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_midblock();
        dec_sel = 2; dout_ready = 1;
        for (int i = 0; i < 2; i++) begin din_en = 1; din = 8'h40; step(); end
        idle_inputs(); rst = 0; step(); rst = 1;
        n_tests++; if (level !== 3'd0 || dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: got lvl %0d valid %0b expected 0/0", level, dout_valid);
        end
        for (int i = 0; i < 4; i++) begin din_en = 1; din = 8'h08; step(); end
        idle_inputs();
        n_tests++; if (dout_valid !== 1'b1 || dout !== 8'h08 || level !== 3'd1) begin
            n_fail++; $display("FAIL rst_mid_result: got %0b/%0h lvl %0d expected 1/08 lvl 1", dout_valid, dout, level);
        end
        step();
    endtask

    task automatic test_random();
        int exp_lvl;
        logic [7:0] exp_dout;
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(0, 199) != 0);
            din_en     = ($urandom_range(0, 3) != 0);
            din        = 8'($urandom);
            if ($urandom_range(0, 9) == 0) din = 8'hFF;
            dec_sel    = 3'($urandom);
            dout_ready = ($urandom_range(0, 3) == 0);
            clr_ovf    = ($urandom_range(0, 15) == 0);
            step();
            exp_lvl  = q.size();
            exp_dout = (q.size() > 0) ? 8'(q[0]) : 8'h00;
            n_tests++; if (level !== 3'(exp_lvl) || dout_valid !== (exp_lvl > 0)) begin
                n_fail++; $display("FAIL rand_level[%0d]: got %0d/%0b expected %0d", c, level, dout_valid, exp_lvl);
            end
            n_tests++; if (dout !== exp_dout) begin
                n_fail++; $display("FAIL rand_dout[%0d]: got %0h expected %0h", c, dout, exp_dout);
            end
            n_tests++; if (ovf !== m_ovf) begin
                n_fail++; $display("FAIL rand_ovf[%0d]: got %0b expected %0b", c, ovf, m_ovf);
            end
        end
        rst = 1; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_avg4();
        test_max_block();
        test_full_fifo();
        test_push_pop_full();
        test_reset_midblock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
